uart_rx_fifo: RTL and testbench

Receive buffer between the UART receiver and the MIPS32 bus interface. Captures each byte the receiver flags as ready, stores it in a circular FIFO, and lets the CPU pop bytes through a registered read port with status, overrun and interrupt signalling. It decouples byte arrival at the baud rate from CPU polling and interrupt latency.

---
 rtl/uart_rx_fifo_pkg.sv | 16 +
 rtl/uart_fifo_mem.sv | 39 +++
 rtl/uart_rx_fifo.sv | 114 +++++++++++
 tb/tb_uart_rx_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive FIFO.
// Default depth/threshold live here beside the other UART receive definitions.
package uart_rx_fifo_pkg;

    localparam int UART_RX_DEPTH_LOG2 = 4;
    localparam int UART_RX_THRESH     = 1;

    // Per-cycle FIFO operation, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// 2^DEPTH_LOG2 x 8 storage: synchronous write port, registered read port.
// The array itself is not reset so it can map onto distributed RAM.
module uart_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem_r [2**DEPTH_LOG2];
    logic [7:0] rd_data_r;

    // Write port; a read of the same address in this cycle still sees the old byte
    always_ff @(posedge Clock) begin
        if (wr_en && !Reset) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, holds its value when no pop occurs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_data_r <= 8'h00;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular FIFO between the receiver and the CPU bus,
// with explicit count, sticky overrun and a registered interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_RX_DEPTH_LOG2,
    parameter int THRESH     = UART_RX_THRESH
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                rx_rdy,
    input  logic [7:0]          rx_data,
    input  logic                rd_en,
    input  logic                clr_ovr,
    output logic [7:0]          rd_data,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                overrun,
    output logic                irq
);

    localparam int              CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(2**DEPTH_LOG2);
    localparam logic [CW-1:0]   THRESH_C = CW'(THRESH);

    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  overrun_r;
    logic                  irq_r;

    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    fifo_op_e              op_s;
    logic [CW-1:0]         count_nxt_s;
    logic                  overrun_nxt_s;
    logic                  irq_nxt_s;

    // Accept/drop decisions and next-state count, overrun and irq
    always_comb begin
        pop_s         = rd_en & ~empty_r;
        // a pop on a full FIFO frees the slot the push needs in the same cycle
        push_s        = rx_rdy & (~full_r | pop_s);
        drop_s        = rx_rdy & full_r & ~pop_s;
        op_s          = fifo_op_e'({push_s, pop_s});
        count_nxt_s   = count_r;
        overrun_nxt_s = overrun_r;

        case (op_s)
            OP_PUSH: count_nxt_s = count_r + CW'(1);
            OP_POP:  count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        if (drop_s) begin
            overrun_nxt_s = 1'b1;
        end else if (clr_ovr) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end

        irq_nxt_s = (count_nxt_s >= THRESH_C) | overrun_nxt_s;
    end

    // Pointer, count and flag registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            count_r   <= count_nxt_s;
            empty_r   <= (count_nxt_s == '0);
            full_r    <= (count_nxt_s == DEPTH_C);
            overrun_r <= overrun_nxt_s;
            irq_r     <= irq_nxt_s;
        end
    end

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (rx_data),
        .rd_en   (pop_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data)
    );

    assign count   = count_r;
    assign empty   = empty_r;
    assign full    = full_r;
    assign overrun = overrun_r;
    assign irq     = irq_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue model predicts flags and popped
// bytes; a separate monitor compares each popped byte against the expected queue.
module tb_uart_rx_fifo;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovr = 1'b0;

    logic [7:0] rd_data,  rd_data4;
    logic       empty,    empty4;
    logic       full,     full4;
    logic [4:0] count,    count4;
    logic       overrun,  overrun4;
    logic       irq,      irq4;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    logic       m_ovr  = 1'b0;

    always #5 Clock = ~Clock;

    uart_rx_fifo #(.DEPTH_LOG2(4), .THRESH(1)) u_dut (
        .Clock(Clock), .Reset(Reset), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rd_en(rd_en), .clr_ovr(clr_ovr), .rd_data(rd_data), .empty(empty),
        .full(full), .count(count), .overrun(overrun), .irq(irq)
    );

    uart_rx_fifo #(.DEPTH_LOG2(4), .THRESH(4)) u_dut4 (
        .Clock(Clock), .Reset(Reset), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rd_en(rd_en), .clr_ovr(clr_ovr), .rd_data(rd_data4), .empty(empty4),
        .full(full4), .count(count4), .overrun(overrun4), .irq(irq4)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = mq.size();
        chk({tag, ":count"},   int'(count),   n);
        chk({tag, ":empty"},   int'(empty),   int'(n == 0));
        chk({tag, ":full"},    int'(full),    int'(n == 16));
        chk({tag, ":overrun"}, int'(overrun), int'(m_ovr));
        chk({tag, ":irq"},     int'(irq),     int'((n >= 1) || m_ovr));
        chk({tag, ":irq4"},    int'(irq4),    int'((n >= 4) || m_ovr));
        chk({tag, ":rd_data"}, int'(rd_data), int'(m_last));
    endtask

    // Drive one cycle from a negedge, update the model, check at the next negedge
    task automatic step(input string tag, input logic push, input logic [7:0] d,
                        input logic pop, input logic clr);
        logic pop_ok, push_ok;
        rx_rdy = push; rx_data = d; rd_en = pop; clr_ovr = clr;
        pop_ok  = pop && (mq.size() > 0);
        push_ok = push && ((mq.size() < 16) || pop_ok);
        if (pop_ok) begin
            m_last = mq.pop_front();
            exp_q.push_back(m_last);
        end
        if (push_ok) mq.push_back(d);
        if (push && !push_ok) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        @(posedge Clock);
        #1;
        rx_rdy = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
        @(negedge Clock);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        mq.delete();
        m_last = 8'h00;
        m_ovr  = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_state(tag);
    endtask

    // Monitor: a pop that fired at this edge must deliver the next scoreboard byte
    initial begin
        logic fire;
        forever begin
            @(posedge Clock);
            fire = rd_en && !empty && !Reset;
            #2;
            if (fire) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_pop: got %0h, expected no pop at %0t", rd_data, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        fails++;
                        $display("FAIL mon_pop: got %0h, expected %0h at %0t", rd_data, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge Clock);
        do_reset("reset0");

        // single byte round trip
        step("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
        step("pop_a5",  1'b0, 8'h00, 1'b1, 1'b0);

        // fill, overflow with FF, drain
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("ovf_ff", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // simultaneous push/pop while full
        for (int i = 0; i < 16; i++) step("fill2", 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        step("both_full", 1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

        // pointer wrap with distinct values
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) step("wrap_push", 1'b1, 8'h40 + 8'(r * 16 + i), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // simultaneous push/pop while empty: push accepted, no bypass
        step("both_empty", 1'b1, 8'h3C, 1'b1, 1'b0);
        step("pop_3c", 1'b0, 8'h00, 1'b1, 1'b0);

        // pop on empty, then overrun set-wins-over-clear
        step("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step("fill3", 1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
        step("drop_clr", 1'b1, 8'h55, 1'b0, 1'b1);
        step("clr_only", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("drain3", 1'b0, 8'h00, 1'b1, 1'b0);

        // reset mid-stream with count 5 (irq4 active beforehand)
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        rx_rdy = 1'b1; rx_data = 8'hEE; rd_en = 1'b1; clr_ovr = 1'b1;
        do_reset("reset5");
        rx_rdy = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
        step("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        repeat (2) @(negedge Clock);
        chk("scoreboard_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
